// File: rtl/sqrt_pkg.sv
// Shared types and helpers for the sqrt_int result buffer.
package sqrt_pkg;

    // Width of radicand, root and remainder; must match the sqrt_int instance.
    localparam int unsigned DATAWIDTH = 8;

    typedef struct packed {
        logic [DATAWIDTH-1:0] root;
        logic [DATAWIDTH-1:0] rem;
    } sqrt_result_t;

    // Returns 1 when {root, rem} is a consistent integer square root of rad:
    // root*root + rem == rad (evaluated at double width) and rem <= 2*root.
    function automatic bit sqrt_check(input logic [DATAWIDTH-1:0] rad,
                                      input logic [DATAWIDTH-1:0] root,
                                      input logic [DATAWIDTH-1:0] rem);
        logic [2*DATAWIDTH-1:0] root_w;
        logic [2*DATAWIDTH-1:0] sum;
        logic [DATAWIDTH:0]     twice_root;
        root_w     = {{DATAWIDTH{1'b0}}, root};
        sum        = root_w * root_w + {{DATAWIDTH{1'b0}}, rem};
        twice_root = {root, 1'b0};
        return (sum == {{DATAWIDTH{1'b0}}, rad}) && ({1'b0, rem} <= twice_root);
    endfunction

endpackage

// File: rtl/sqrt_resbuf_fifo.sv
// Synchronous first-word fall-through FIFO with occupancy count.
// A push while full is accepted only if a pop happens in the same cycle.
module sqrt_resbuf_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem[rd_ptr_q];
    assign do_pop  = pop & !empty;
    assign do_push = push & (!full | do_pop);

    // Occupancy follows accepted pushes and pops.
    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers wrap naturally at power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sqrt_result_buffer.sv
// Credit-based issue and in-order result buffer for the sqrt_int pipeline.
// sqrt_int cannot stall, so a request is only issued when a result slot is
// guaranteed: credits + outstanding + count == DEPTH at all times.
// Optional feature: define SQRT_RESBUF_CHECK_EN to cross-check every result
// against the radicand it was issued for (err_check).
module sqrt_result_buffer #(
    parameter int unsigned DATAWIDTH = sqrt_pkg::DATAWIDTH,
    parameter int unsigned DEPTH     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [DATAWIDTH-1:0]       req_rad,
    output logic                       sq_i_valid,
    output logic [DATAWIDTH-1:0]       sq_rad,
    input  logic                       sq_o_valid,
    input  logic [DATAWIDTH-1:0]       sq_root,
    input  logic [DATAWIDTH-1:0]       sq_rem,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [DATAWIDTH-1:0]       res_root,
    output logic [DATAWIDTH-1:0]       res_rem,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err_proto,
    output logic                       err_check
);

    import sqrt_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [CW-1:0]          credits_q;
    logic [CW-1:0]          credits_d;
    logic [CW-1:0]          outstanding_q;
    logic [CW-1:0]          outstanding_d;
    logic                   issue;
    logic                   pop;
    logic                   push_ok;
    logic                   proto_bad;
    logic                   check_bad;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [2*DATAWIDTH-1:0] head;
    logic                   err_proto_q;
    logic                   err_check_q;

    assign req_ready  = (credits_q != '0);
    assign issue      = req_valid & req_ready;
    assign sq_i_valid = issue;
    assign sq_rad     = req_rad;

    assign res_valid  = !fifo_empty;
    assign pop        = res_valid & res_ready;

    // A result is taken only if one is owed and there is room for it.
    assign push_ok    = sq_o_valid & (outstanding_q != '0) & (!fifo_full | pop);
    assign proto_bad  = sq_o_valid & !push_ok;

    assign res_root   = head[2*DATAWIDTH-1:DATAWIDTH];
    assign res_rem    = head[DATAWIDTH-1:0];
    assign err_proto  = err_proto_q;
    assign err_check  = err_check_q;

    sqrt_resbuf_fifo #(
        .WIDTH (2 * DATAWIDTH),
        .DEPTH (DEPTH)
    ) u_result_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_ok),
        .pop     (pop),
        .wr_data ({sq_root, sq_rem}),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

`ifdef SQRT_RESBUF_CHECK_EN
    // Shadow FIFO holds issued radicands in order; each accepted result
    // retires the oldest one.
    logic [DATAWIDTH-1:0] shadow_rad;
    logic                 shadow_empty;
    logic                 shadow_full;
    logic [CW-1:0]        shadow_count;
    logic                 unused_shadow;
    sqrt_result_t         got;

    sqrt_resbuf_fifo #(
        .WIDTH (DATAWIDTH),
        .DEPTH (DEPTH)
    ) u_shadow_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (issue),
        .pop     (push_ok),
        .wr_data (sq_rad),
        .rd_data (shadow_rad),
        .full    (shadow_full),
        .empty   (shadow_empty),
        .count   (shadow_count)
    );

    assign unused_shadow = ^{shadow_full, shadow_count};
    assign got           = '{root: sq_root, rem: sq_rem};
    assign check_bad     = push_ok & (shadow_empty | !sqrt_check(shadow_rad, got.root, got.rem));
`else
    assign check_bad = 1'b0;
`endif

    // Credits: consumed on issue, returned when the consumer pops.
    always_comb begin
        credits_d = credits_q;
        unique case ({issue, pop})
            2'b10:   credits_d = credits_q - 1'b1;
            2'b01:   credits_d = credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    // Outstanding: requests inside sqrt_int whose result is not yet stored.
    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({issue, push_ok})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Counter and sticky error state; reset also discards in-flight results.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits_q     <= CW'(DEPTH);
            outstanding_q <= '0;
            err_proto_q   <= 1'b0;
            err_check_q   <= 1'b0;
        end else begin
            credits_q     <= credits_d;
            outstanding_q <= outstanding_d;
            if (proto_bad) err_proto_q <= 1'b1;
            if (check_bad) err_check_q <= 1'b1;
        end
    end

endmodule
